// File: rtl/click_decoder_if.sv
// Event handshake between the click decoder and its consumer.
// master presents evt_valid/evt_count; slave returns evt_ready.
interface click_decoder_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_count;

  modport master (output evt_valid, output evt_count, input evt_ready);
  modport slave  (input evt_valid, input evt_count, output evt_ready);
endinterface

// File: rtl/click_decoder.sv
// Groups debounced press pulses into single/double/triple click events; timeout close at press+CLICK_WINDOW+1, max-count close next cycle.
// Event held in REPORT until evt_ready; presses arriving while it waits are dropped and flagged one cycle later.
module click_decoder #(
  parameter int CLICK_WINDOW = 5,
  parameter int MAX_CLICKS   = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   press_pulse,
  click_decoder_if.master        evt,
  output logic                   evt_dropped,
  output logic                   busy
);

  localparam int TW = $clog2(CLICK_WINDOW);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATHER = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    click_cnt, cnt_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [1:0]    count_q, count_nxt;
  logic          drop_q, drop_nxt;
  logic [1:0]    cnt_inc;

  assign cnt_inc = click_cnt + 2'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      click_cnt <= 2'd0;
      timer     <= '0;
      count_q   <= 2'd0;
      drop_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      click_cnt <= cnt_nxt;
      timer     <= timer_nxt;
      count_q   <= count_nxt;
      drop_q    <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = click_cnt;
    timer_nxt = timer;
    count_nxt = count_q;
    drop_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (press_pulse) begin
          cnt_nxt   = 2'd1;
          timer_nxt = '0;
          if (MAX_CLICKS == 1) begin
            state_nxt = REPORT;
            count_nxt = 2'd1;
          end else begin
            state_nxt = GATHER;
          end
        end
      end
      GATHER: begin
        // A press on the expiry cycle still joins the event and restarts the window.
        if (press_pulse) begin
          cnt_nxt   = cnt_inc;
          timer_nxt = '0;
          if (cnt_inc == 2'(MAX_CLICKS)) begin
            state_nxt = REPORT;
            count_nxt = cnt_inc;
          end
        end else if (timer == TW'(CLICK_WINDOW - 1)) begin
          state_nxt = REPORT;
          count_nxt = click_cnt;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      REPORT: begin
        if (evt.evt_ready) begin
          timer_nxt = '0;
          if (press_pulse) begin
            cnt_nxt = 2'd1;
            if (MAX_CLICKS == 1) begin
              state_nxt = REPORT;
              count_nxt = 2'd1;
            end else begin
              state_nxt = GATHER;
            end
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = 2'd0;
          end
        end else if (press_pulse) begin
          drop_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 2'd0;
        timer_nxt = '0;
      end
    endcase
  end

  assign evt.evt_valid = (state == REPORT);
  assign evt.evt_count = count_q;
  assign evt_dropped   = drop_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_click_decoder.sv
// Directed bench for click_decoder: per-cycle press/ready masks, outputs logged each cycle
// and compared against hand-computed cycle numbers (reset released at cycle 3).
module tb_click_decoder;

  logic clk;
  logic reset;
  logic press_pulse;
  logic evt_dropped;
  logic busy;

  click_decoder_if eif ();

  click_decoder #(.CLICK_WINDOW(5), .MAX_CLICKS(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .press_pulse (press_pulse),
    .evt         (eif),
    .evt_dropped (evt_dropped),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic       v_log [64];
  logic [1:0] c_log [64];
  logic       d_log [64];
  logic       b_log [64];

  localparam logic [63:0] RDY_ALL = '1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Cycle c spans posedge c to posedge c+1; inputs change 1ns after the edge, outputs logged at negedge.
  task automatic run(input logic [63:0] pm, input logic [63:0] rm, input int rst_lo, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      reset       = (c >= 3) && !(c >= rst_lo && c < rst_lo + 2);
      press_pulse = pm[c];
      eif.evt_ready = rm[c];
      @(negedge clk);
      v_log[c] = eif.evt_valid;
      c_log[c] = eif.evt_count;
      d_log[c] = evt_dropped;
      b_log[c] = busy;
    end
    @(posedge clk);
    #1;
    press_pulse = 1'b0;
  endtask

  function automatic int nvalid(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (v_log[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic logic [63:0] bits(input int a, input int b, input int c);
    logic [63:0] m = '0;
    if (a >= 0) m[a] = 1'b1;
    if (b >= 0) m[b] = 1'b1;
    if (c >= 0) m[c] = 1'b1;
    return m;
  endfunction

  initial begin
    logic [63:0] rdy_late;
    reset = 1'b0;
    press_pulse = 1'b0;
    eif.evt_ready = 1'b0;

    // single click, timeout close
    run(bits(10, -1, -1), RDY_ALL, -10, 40);
    check("rst_valid", v_log[1], 0);
    check("rst_count", c_log[1], 0);
    check("rst_drop", d_log[1], 0);
    check("rst_busy", b_log[1], 0);
    check("s1_busy10", b_log[10], 0);
    check("s1_busy11", b_log[11], 1);
    check("s1_busy16", b_log[16], 1);
    check("s1_busy17", b_log[17], 0);
    check("s1_v15", v_log[15], 0);
    check("s1_v16", v_log[16], 1);
    check("s1_c16", c_log[16], 1);
    check("s1_v17", v_log[17], 0);
    check("s1_nev", nvalid(0, 39), 1);

    // double click within window
    run(bits(10, 13, -1), RDY_ALL, -10, 40);
    check("s2_v18", v_log[18], 0);
    check("s2_v19", v_log[19], 1);
    check("s2_c19", c_log[19], 2);
    check("s2_v20", v_log[20], 0);
    check("s2_nev", nvalid(0, 39), 1);

    // gap 6: two singles, second press lands in transfer cycle
    run(bits(10, 16, -1), RDY_ALL, -10, 40);
    check("s3_v16", v_log[16], 1);
    check("s3_c16", c_log[16], 1);
    check("s3_v17", v_log[17], 0);
    check("s3_busy17", b_log[17], 1);
    check("s3_v21", v_log[21], 0);
    check("s3_v22", v_log[22], 1);
    check("s3_c22", c_log[22], 1);
    check("s3_nev", nvalid(0, 39), 2);

    // triple click closes immediately
    run(bits(10, 12, 14), RDY_ALL, -10, 40);
    check("s4_v14", v_log[14], 0);
    check("s4_v15", v_log[15], 1);
    check("s4_c15", c_log[15], 3);
    check("s4_v16", v_log[16], 0);
    check("s4_nev", nvalid(0, 39), 1);

    // press exactly on timer expiry joins the event
    run(bits(10, 15, -1), RDY_ALL, -10, 40);
    check("s5_v16", v_log[16], 0);
    check("s5_v20", v_log[20], 0);
    check("s5_v21", v_log[21], 1);
    check("s5_c21", c_log[21], 2);
    check("s5_nev", nvalid(0, 39), 1);

    // consumer stalls; two presses dropped back to back
    rdy_late = '0;
    for (int i = 20; i < 64; i++) rdy_late[i] = 1'b1;
    run(bits(10, 17, 18), rdy_late, -10, 40);
    check("s6_v16", v_log[16], 1);
    check("s6_d17", d_log[17], 0);
    check("s6_d18", d_log[18], 1);
    check("s6_d19", d_log[19], 1);
    check("s6_d20", d_log[20], 0);
    check("s6_c19", c_log[19], 1);
    check("s6_v20", v_log[20], 1);
    check("s6_v21", v_log[21], 0);
    check("s6_busy21", b_log[21], 0);
    check("s6_nev", nvalid(0, 39), 5);

    // async reset mid-GATHER after two presses
    run(bits(10, 12, -1), RDY_ALL, 13, 40);
    check("s7_busy12", b_log[12], 1);
    check("s7_busy13", b_log[13], 0);
    check("s7_v13", v_log[13], 0);
    check("s7_c13", c_log[13], 0);
    check("s7_d13", d_log[13], 0);
    check("s7_busy20", b_log[20], 0);
    check("s7_nev", nvalid(13, 39), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
